dsp_result_collector: RTL



---
 rtl/dsp_result_collector_pkg.sv | 19 +
 rtl/dsp_result_collector_fifo.sv | 77 +++++++
 rtl/dsp_result_collector.sv | 94 +++++++++
 3 files changed

// File: rtl/dsp_result_collector_pkg.sv
// Shared definitions for the DSP48A1 slice wrapper: default geometry and the
// captured-result record {carry, p}.
package dsp48a1_pkg;

  localparam int P_WIDTH_DEF = 48;
  localparam int LATENCY_DEF = 4;
  localparam int DEPTH_DEF   = 4;

  typedef struct packed {
    logic                   carry;
    logic [P_WIDTH_DEF-1:0] p;
  } result_t;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dsp_result_collector_fifo.sv
// Synchronous FIFO holding captured slice results; push into a full buffer
// and pop from an empty buffer are ignored.
module result_fifo_sync
  import dsp48a1_pkg::*;
#(
  parameter int WIDTH = P_WIDTH_DEF + 1,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [WIDTH-1:0]              wr_data_i,
  output logic [WIDTH-1:0]              rd_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [count_width(DEPTH)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_s, pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign push_s    = push_i & ~full_o;
  assign pop_s     = pop_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dsp_result_collector.sv
// Tracks operations through the fixed slice latency, captures each P/CARRYOUT
// result as it emerges and hands it downstream, issuing credits so the buffer
// can never overflow.
module dsp_result_collector
  import dsp48a1_pkg::*;
#(
  parameter int P_WIDTH = P_WIDTH_DEF,
  parameter int LATENCY = LATENCY_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue,
  output logic                          issue_ready,
  input  logic [P_WIDTH-1:0]            p_in,
  input  logic                          carryout_in,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [P_WIDTH-1:0]            res_p,
  output logic                          res_carry,
  output logic [count_width(DEPTH)-1:0] res_count,
  output logic                          overflow_err
);

  localparam int CW    = count_width(DEPTH);
  localparam int OCC_W = CW + 1;

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0]      in_flight_q, in_flight_d;
  logic               overflow_q, overflow_d;
  logic               accept_s, emerge_s, push_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [OCC_W-1:0]   occupancy_s;
  logic [P_WIDTH:0]   head_s;

  // Credit is judged on registered state only, so a pop frees a slot one cycle later.
  assign occupancy_s  = {1'b0, res_count} + {1'b0, in_flight_q};
  assign issue_ready  = (occupancy_s < OCC_W'(DEPTH));
  assign accept_s     = issue & issue_ready;
  assign emerge_s     = tag_q[LATENCY-1];
  assign push_s       = emerge_s & ~fifo_full_s;
  assign overflow_err = overflow_q;
  assign res_valid    = ~fifo_empty_s;
  assign res_p        = head_s[P_WIDTH-1:0];
  assign res_carry    = head_s[P_WIDTH];

  // Tag pipe shift, in-flight accounting and sticky rejected-issue flag.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = accept_s;
    for (int i = 1; i < LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    case ({accept_s, emerge_s})
      2'b10:   in_flight_d = in_flight_q + CW'(1);
      2'b01:   in_flight_d = in_flight_q - CW'(1);
      default: in_flight_d = in_flight_q;
    endcase
    if (issue && !issue_ready) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Tracking state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q       <= {LATENCY{1'b0}};
      in_flight_q <= {CW{1'b0}};
      overflow_q  <= 1'b0;
    end else begin
      tag_q       <= tag_d;
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
    end
  end

  result_fifo_sync #(
    .WIDTH (P_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .reset_i   (reset),
    .push_i    (push_s),
    .pop_i     (res_ready),
    .wr_data_i ({carryout_in, p_in}),
    .rd_data_o (head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (res_count)
  );

endmodule
